// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with a memory-ready handshake on fetch and data accesses.
// Optional bne support is enabled by defining MIPS_MC_BNE_EN.
module mips_mc_control #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       irwrite,
    output logic       pc_en,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   set_illegal;
    logic   pcwrite;
    logic   branch;
    logic   branch_taken;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= FETCH;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            illegal <= illegal | set_illegal;
        end
    end

`ifdef MIPS_MC_BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;
    logic bne_q;

    // Opcode may change after DECODE, so branch polarity is latched there.
    always_ff @(posedge clock) begin
        if (rst) begin
            bne_q <= 1'b0;
        end else if (state_q == DECODE) begin
            bne_q <= (opcode == OP_BNE);
        end
    end

    assign branch_taken = bne_q ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsrc       = 2'b00;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = ILLEGAL_HALT ? HALT : FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign pc_en = pcwrite | (branch & branch_taken);
    assign state = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed vector table, multi-cycle
// corner sequences and randomized instruction streams against a reference model.
module tb_mips_mc_control;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [3:0] state, h_state;
    logic       mem_req, mem_we, iord, irwrite, pc_en, regwrite, regdst, memtoreg, alusrca, illegal;
    logic       h_mem_req, h_mem_we, h_iord, h_irwrite, h_pc_en, h_regwrite, h_regdst, h_memtoreg;
    logic       h_alusrca, h_illegal;
    logic [1:0] alusrcb, aluop, pcsrc, h_alusrcb, h_aluop, h_pcsrc;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mips_mc_control dut (
        .clock(clock), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .state(state), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .irwrite(irwrite),
        .pc_en(pc_en), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .illegal(illegal)
    );

    mips_mc_control #(.ILLEGAL_HALT(1'b1)) dut_h (
        .clock(clock), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .state(h_state), .mem_req(h_mem_req), .mem_we(h_mem_we), .iord(h_iord),
        .irwrite(h_irwrite), .pc_en(h_pc_en), .regwrite(h_regwrite), .regdst(h_regdst),
        .memtoreg(h_memtoreg), .alusrca(h_alusrca), .alusrcb(h_alusrcb), .aluop(h_aluop),
        .pcsrc(h_pcsrc), .illegal(h_illegal)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       irwrite;
        logic       pc_en;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctl_t;

    ctl_t act_ctl, h_ctl;
    assign act_ctl = {mem_req, mem_we, iord, irwrite, pc_en, regwrite, regdst, memtoreg,
                      alusrca, alusrcb, aluop, pcsrc};
    assign h_ctl   = {h_mem_req, h_mem_we, h_iord, h_irwrite, h_pc_en, h_regwrite, h_regdst,
                      h_memtoreg, h_alusrca, h_alusrcb, h_aluop, h_pcsrc};

    typedef enum {C_LW, C_SW, C_R, C_BR, C_ADDI, C_J, C_ILL} cls_t;

    typedef struct {
        bit         mr;
        logic [5:0] op;
        bit         z;
        logic [3:0] st;
        bit         rw, rd, mt, pe, ill;
    } vec_t;

    typedef struct {
        int st;
        bit mr;
    } step_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b000100: return C_BR;
`ifdef MIPS_MC_BNE_EN
            6'b000101: return C_BR;
`endif
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    // Expected datapath controls for each state, read off the state descriptions.
    function automatic ctl_t exp_ctl(input int st, input bit mr, input bit z, input bit is_bne);
        ctl_t c = '0;
        case (st)
            0:  begin c.mem_req = 1; c.irwrite = mr; c.pc_en = mr; c.alusrcb = 2'b01; end
            1:  c.alusrcb = 2'b11;
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            3:  begin c.mem_req = 1; c.iord = 1; end
            4:  begin c.regwrite = 1; c.memtoreg = 1; end
            5:  begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2'b10; end
            7:  begin c.regwrite = 1; c.regdst = 1; end
            8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pc_en = is_bne ? ~z : z; end
            9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            10: c.regwrite = 1;
            11: begin c.pcsrc = 2'b10; c.pc_en = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic vec_t mk(bit mr, logic [5:0] op, bit z, logic [3:0] st,
                                bit rw, bit rd, bit mt, bit pe, bit ill);
        vec_t v;
        v.mr = mr; v.op = op; v.z = z; v.st = st;
        v.rw = rw; v.rd = rd; v.mt = mt; v.pe = pe; v.ill = ill;
        return v;
    endfunction

    initial begin
        vec_t  tbl[$];
        step_t q[$];
        bit    exp_ill;
        bit    bne_ill;

`ifdef MIPS_MC_BNE_EN
        bne_ill = 1'b0;
`else
        bne_ill = 1'b1;
`endif
        // R-type: 0,1,6,7
        tbl.push_back(mk(1, 6'b000000, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6'b000000, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6'b000000, 0, 6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6'b000000, 0, 7, 1, 1, 0, 0, 0));
        // lw with two wait cycles in MEMRD
        tbl.push_back(mk(1, 6'b100011, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6'b100011, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6'b100011, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'b100011, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'b100011, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6'b100011, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6'b100011, 0, 4, 1, 0, 1, 0, 0));
        // beq taken, then not taken
        tbl.push_back(mk(1, 6'b000100, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6'b000100, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6'b000100, 1, 8, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6'b000100, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6'b000100, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6'b000100, 0, 8, 0, 0, 0, 0, 0));
        // bne with zero = 0: taken branch, or illegal without the option
        tbl.push_back(mk(1, 6'b000101, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6'b000101, 0, 1, 0, 0, 0, 0, 0));
`ifdef MIPS_MC_BNE_EN
        tbl.push_back(mk(1, 6'b000101, 0, 8, 0, 0, 0, 1, 0));
`endif
        tbl.push_back(mk(0, 6'b000000, 0, 0, 0, 0, 0, 0, bne_ill));

        do_reset();
        check("reset_state", 32'(state), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            mem_ready = tbl[i].mr;
            opcode    = tbl[i].op;
            zero      = tbl[i].z;
            @(negedge clock);
            check($sformatf("vec%0d", i),
                  32'({state, regwrite, regdst, memtoreg, pc_en, illegal}),
                  32'({tbl[i].st, tbl[i].rw, tbl[i].rd, tbl[i].mt, tbl[i].pe, tbl[i].ill}));
            if (tbl[i].st == 4'd8)
                check($sformatf("vec%0d_pcsrc", i), 32'(pcsrc), 32'd1);
            tick();
        end

        // Unknown opcode with ILLEGAL_HALT = 1: DECODE then HALT until reset.
        do_reset();
        opcode = 6'b111111;
        mem_ready = 1'b1;
        @(negedge clock);
        check("halt_fetch", 32'(h_state), 32'd0);
        tick();
        @(negedge clock);
        check("halt_decode", 32'({h_state, h_illegal}), 32'({4'd1, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clock);
            check($sformatf("halt_hold%0d", i), 32'({h_state, h_illegal}), 32'({4'd12, 1'b1}));
            check($sformatf("halt_ctl%0d", i), 32'(h_ctl), 32'd0);
        end
        do_reset();
        @(negedge clock);
        check("halt_reset", 32'({h_state, h_illegal}), 32'({4'd0, 1'b0}));

        // Reset in MEMWR while memory is stalled.
        opcode = 6'b101011;
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        @(negedge clock);
        check("memwr_state", 32'({state, mem_we, mem_req}), 32'({4'd5, 1'b1, 1'b1}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clock);
        check("memwr_reset_state", 32'({state, illegal}), 32'({4'd0, 1'b0}));
        check("memwr_reset_we",
              32'({mem_we, regwrite, irwrite, pc_en}), 32'd0);

        // Randomized instruction stream against the instruction-level model.
        do_reset();
        exp_ill = 1'b0;
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            cls_t       cls;
            int         w;
            bit         is_bne;
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: op = 6'b000101;
                default: op = 6'($urandom_range(0, 63));
            endcase
            cls    = classify(op);
            is_bne = (op == 6'b000101);
            q.delete();
            w = $urandom_range(0, 2);
            repeat (w) q.push_back('{0, 1'b0});
            q.push_back('{0, 1'b1});
            q.push_back('{1, 1'($urandom)});
            case (cls)
                C_LW: begin
                    q.push_back('{2, 1'($urandom)});
                    w = $urandom_range(0, 3);
                    repeat (w) q.push_back('{3, 1'b0});
                    q.push_back('{3, 1'b1});
                    q.push_back('{4, 1'($urandom)});
                end
                C_SW: begin
                    q.push_back('{2, 1'($urandom)});
                    w = $urandom_range(0, 3);
                    repeat (w) q.push_back('{5, 1'b0});
                    q.push_back('{5, 1'b1});
                end
                C_R: begin
                    q.push_back('{6, 1'($urandom)});
                    q.push_back('{7, 1'($urandom)});
                end
                C_BR:   q.push_back('{8, 1'($urandom)});
                C_ADDI: begin
                    q.push_back('{9, 1'($urandom)});
                    q.push_back('{10, 1'($urandom)});
                end
                C_J:    q.push_back('{11, 1'($urandom)});
                default: ;
            endcase
            foreach (q[k]) begin
                opcode    = op;
                mem_ready = q[k].mr;
                zero      = 1'($urandom);
                @(negedge clock);
                check($sformatf("rnd%0d_state", n), 32'(state), 32'(q[k].st));
                check($sformatf("rnd%0d_ctl_s%0d", n, q[k].st), 32'(act_ctl),
                      32'(exp_ctl(q[k].st, q[k].mr, zero, is_bne)));
                check($sformatf("rnd%0d_illegal", n), 32'(illegal), 32'(exp_ill));
                tick();
                if (q[k].st == 1 && cls == C_ILL) exp_ill = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle control FSM that sequences the MIPS datapath: PC/IR update, register file, ALU muxing and memory access.
- Instantiated inside MIPS next to the datapath; its `state` output drives the top-level `state` port.
- Adds a memory-ready handshake so fetch and data accesses can stall for wait-stated memory.

Parameters:
- ILLEGAL_HALT, 0: 0 = unknown opcode returns to FETCH; 1 = unknown opcode enters HALT until reset.

Ports:
- clock  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  instr[31:26] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- state  out  4  current FSM state encoding
- mem_req  out  1  memory access active
- mem_we  out  1  write strobe (valid with mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  load IR
- pc_en  out  1  PC load = pcwrite | (branch & zero)
- regwrite  out  1  register file write
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = MDR, 0 = ALUOut
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
- aluop  out  2  00 = add, 01 = sub, 10 = funct
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  out  1  sticky flag: unknown opcode decoded

Behaviour:
- Only `state` and `illegal` are registered. All other outputs are combinational decodes of state, plus mem_ready/zero where noted. Unlisted outputs are 0.
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11, HALT = 12
  - Codes 13-15 are unreachable; if entered, go to FETCH next cycle.
- Reset: on rst high at a clock edge, state = FETCH and illegal = 0. rst mid-instruction aborts it; no write enable is asserted in the cycle after the reset edge.
- FETCH:
  - Outputs: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite and pcwrite are asserted only when mem_ready = 1.
  - Next state is DECODE if mem_ready, else stay in FETCH.
- DECODE:
  - Outputs: alusrca = 0, alusrcb = 11, aluop = 00 (branch target computed into ALUOut).
  - Next state by opcode:
    - 100011 lw or 101011 sw -> MEMADR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEX
    - 000010 j -> JUMP
    - any other opcode -> set illegal; go to FETCH (ILLEGAL_HALT = 0) or HALT (ILLEGAL_HALT = 1).
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1. Stays until mem_ready, then MEMWB.
- MEMWB: regwrite = 1, regdst = 0, memtoreg = 1. Next state FETCH.
- MEMWR: mem_req = 1, mem_we = 1, iord = 1. Stays until mem_ready, then FETCH.
- EXECUTE: alusrca = 1, alusrcb = 00, aluop = 10. Next state ALUWB.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0. Next state FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, branch = 1, so pc_en = zero. Next state FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00. Next state ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0. Next state FETCH.
- JUMP: pcsrc = 10, pcwrite = 1. Next state FETCH.
- HALT: all enables 0, mem_req = 0. Exit only via rst.
- Instruction latency with mem_ready tied high:
  - beq / j: 3 cycles
  - R-type / sw / addi: 4 cycles
  - lw: 5 cycles
  - Each wait cycle (mem_ready low) in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all other states.
- illegal is sticky and is cleared only by rst.

Optional Feature:
- Macro: MIPS_MC_BNE_EN.
- When defined: opcode 000101 (bne) decodes to BRANCH. In BRANCH, pc_en = ~zero for bne and zero for beq; the controller uses an internal registered bne flag captured in DECODE.
- When undefined: 000101 is treated as an illegal opcode.

Test Plan:
- rst high for 1 edge, then low, mem_ready = 1, opcode = 000000 -> state sequence 0, 1, 6, 7, 0; regwrite = 1 and regdst = 1 only in state 7; illegal = 0.
- opcode = 100011, mem_ready low for 2 cycles in MEMRD -> sequence 0, 1, 2, 3, 3, 3, 4, 0; memtoreg = 1 and regwrite = 1 in state 4.
- opcode = 000100 with zero = 1, then repeat with zero = 0 -> pc_en = 1 / 0 in state 8; pcsrc = 01; 3-cycle instruction.
- opcode = 111111, ILLEGAL_HALT = 1 -> state 1 then 12; illegal = 1 and held; rst returns state to 0 with illegal = 0.
- Assert rst while in state 5 with mem_ready = 0 -> next state 0; mem_we = 0 from the reset edge onward.
- MIPS_MC_BNE_EN defined, opcode = 000101, zero = 0 -> pc_en = 1 in state 8. Macro undefined -> illegal = 1 and state returns to 0.
